// File: rtl/pll_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pll_pkg                                                          |
// | Purpose  : Shared lock-state encoding and saturating narrow for the PLL     |
// |            lock detector.                                                   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package pll_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLD     = 2'd3
    } lock_state_e;

    // Clamp a wide signed value into the dw-bit signed range (dw <= 32).
    function automatic logic signed [31:0] sat_dw(input logic signed [63:0] val, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (val > hi) begin
            return 32'(hi);
        end else if (val < lo) begin
            return 32'(lo);
        end
        return 32'(val);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_iq_correlator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pll_iq_correlator                                                |
// | Purpose  : I/Q product stage and fixed-window integrator producing means.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module pll_iq_correlator
    import pll_pkg::*;
#(
    parameter int DW       = 12,
    parameter int WIN_LOG2 = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_in,
    input  logic signed [DW-1:0] i_sin,
    input  logic signed [DW-1:0] i_cos,
    output logic signed [DW-1:0] o_mean_i,
    output logic signed [DW-1:0] o_mean_q,
    output logic                 o_win_valid
);

    localparam int c_aw = DW + WIN_LOG2;

    logic signed [DW:0]         w_neg_sin;
    logic signed [2*DW-1:0]     w_prod_i;
    logic signed [2*DW:0]       w_prod_q;
    logic signed [31:0]         w_sat_i;
    logic signed [31:0]         w_sat_q;
    logic signed [c_aw-1:0]     w_sum_i;
    logic signed [c_aw-1:0]     w_sum_q;

    logic                       r_en_d;
    logic signed [DW-1:0]       r_pi;
    logic signed [DW-1:0]       r_pq;
    logic [WIN_LOG2-1:0]        r_cnt;
    logic signed [c_aw-1:0]     r_acc_i;
    logic signed [c_aw-1:0]     r_acc_q;

    // One extra bit keeps -(-2^(DW-1)) representable.
    assign w_neg_sin = -((DW+1)'(i_sin));
    assign w_prod_i  = (2*DW)'(i_in) * (2*DW)'(i_cos);
    assign w_prod_q  = (2*DW+1)'(i_in) * (2*DW+1)'(w_neg_sin);
    assign w_sat_i   = sat_dw(64'(w_prod_i >>> (DW - 1)), DW);
    assign w_sat_q   = sat_dw(64'(w_prod_q >>> (DW - 1)), DW);
    assign w_sum_i   = r_acc_i + c_aw'(r_pi);
    assign w_sum_q   = r_acc_q + c_aw'(r_pq);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en_d      <= 1'b0;
            r_pi        <= '0;
            r_pq        <= '0;
            r_cnt       <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            o_mean_i    <= '0;
            o_mean_q    <= '0;
            o_win_valid <= 1'b0;
        end else begin
            r_en_d      <= i_en;
            o_win_valid <= 1'b0;
            if (i_en) begin
                r_pi <= DW'(w_sat_i);
                r_pq <= DW'(w_sat_q);
            end
            if (r_en_d) begin
                r_cnt <= r_cnt + WIN_LOG2'(1);
                if (&r_cnt) begin
                    o_mean_i    <= DW'(w_sum_i >>> WIN_LOG2);
                    o_mean_q    <= DW'(w_sum_q >>> WIN_LOG2);
                    o_win_valid <= 1'b1;
                    r_acc_i     <= '0;
                    r_acc_q     <= '0;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_lock_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pll_lock_detector                                                |
// | Purpose  : Windowed I/Q correlation with hysteretic lock/unlock decision.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module pll_lock_detector
    import pll_pkg::*;
#(
    parameter int DW         = 12,
    parameter int WIN_LOG2   = 16,
    parameter int LOCK_THR   = 512,
    parameter int UNLOCK_THR = 256,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_in,
    input  logic signed [DW-1:0] i_sin,
    input  logic signed [DW-1:0] i_cos,
    output logic signed [DW-1:0] o_mean_i,
    output logic signed [DW-1:0] o_mean_q,
    output logic                 o_win_valid,
    output logic                 o_locked,
    output logic                 o_lock_lost
);

    localparam int                   c_gw         = $clog2(LOCK_CNT + 1);
    localparam int                   c_bw         = $clog2(UNLOCK_CNT + 1);
    localparam logic signed [DW-1:0] c_lock_thr   = DW'(LOCK_THR);
    localparam logic signed [DW-1:0] c_unlock_thr = DW'(UNLOCK_THR);

    lock_state_e       r_state;
    lock_state_e       w_state_nxt;
    logic [c_gw-1:0]   r_gcnt;
    logic [c_gw-1:0]   w_gcnt_nxt;
    logic [c_gw-1:0]   w_gcnt_inc;
    logic [c_bw-1:0]   r_bcnt;
    logic [c_bw-1:0]   w_bcnt_nxt;
    logic [c_bw-1:0]   w_bcnt_inc;
    logic              w_good;
    logic              w_bad;
    logic              w_lost_nxt;

    pll_iq_correlator #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_corr (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_in        (i_in),
        .i_sin       (i_sin),
        .i_cos       (i_cos),
        .o_mean_i    (o_mean_i),
        .o_mean_q    (o_mean_q),
        .o_win_valid (o_win_valid)
    );

    // Signed compares: a mean from an anti-phase lock is never good.
    assign w_good     = (o_mean_i >= c_lock_thr);
    assign w_bad      = (o_mean_i <  c_unlock_thr);
    assign w_gcnt_inc = r_gcnt + c_gw'(1);
    assign w_bcnt_inc = r_bcnt + c_bw'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= UNLOCKED;
            r_gcnt      <= '0;
            r_bcnt      <= '0;
            o_locked    <= 1'b0;
            o_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_bcnt      <= w_bcnt_nxt;
            o_locked    <= (w_state_nxt == LOCKED) || (w_state_nxt == HOLD);
            o_lock_lost <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_bcnt_nxt  = r_bcnt;
        w_lost_nxt  = 1'b0;
        if (o_win_valid) begin
            case (r_state)
                UNLOCKED: begin
                    if (w_good) begin
                        if (LOCK_CNT == 1) begin
                            w_state_nxt = LOCKED;
                            w_gcnt_nxt  = '0;
                        end else begin
                            w_state_nxt = ACQUIRE;
                            w_gcnt_nxt  = c_gw'(1);
                        end
                    end
                end
                ACQUIRE: begin
                    if (!w_good) begin
                        w_state_nxt = UNLOCKED;
                        w_gcnt_nxt  = '0;
                    end else if (w_gcnt_inc == c_gw'(LOCK_CNT)) begin
                        w_state_nxt = LOCKED;
                        w_gcnt_nxt  = '0;
                    end else begin
                        w_gcnt_nxt  = w_gcnt_inc;
                    end
                end
                LOCKED: begin
                    if (w_bad) begin
                        if (UNLOCK_CNT == 1) begin
                            w_state_nxt = UNLOCKED;
                            w_lost_nxt  = 1'b1;
                            w_bcnt_nxt  = '0;
                        end else begin
                            w_state_nxt = HOLD;
                            w_bcnt_nxt  = c_bw'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!w_bad) begin
                        w_state_nxt = LOCKED;
                        w_bcnt_nxt  = '0;
                    end else if (w_bcnt_inc == c_bw'(UNLOCK_CNT)) begin
                        w_state_nxt = UNLOCKED;
                        w_lost_nxt  = 1'b1;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt  = w_bcnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = UNLOCKED;
                    w_gcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
